acumulador_param: RTL and testbench
===================================

Name: acumulador_param

Overview:
Parametrised streaming accumulator that generalises the 8-bit adder plus load register pair into one sequential block.
- Accepts a frame of WIDTH-bit operands over a valid/ready handshake.
- Adds or subtracts each operand into an ACC_WIDTH-bit accumulator, in signed or unsigned mode.
- Optionally saturates instead of wrapping.
- Holds the frame result behind an output valid/ready handshake.
- Sits between operand producers and any consumer of the sum, sign or overflow flags.

Parameters:
WIDTH, 8, operand width in bits (>=2).
ACC_WIDTH, 12, accumulator/result width (>= WIDTH+1).
MAX_OPERANDOS, 16, operand count that force-closes a frame (>=1).
SATURA, 0, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
modo_sinal  input  1  1 = two's-complement signed, 0 = unsigned; sampled with first beat of a frame.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat.
in_dado  input  WIDTH  operand.
in_sub  input  1  1 = subtract this operand, 0 = add.
in_ultimo  input  1  marks last operand of frame.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
out_soma  output  ACC_WIDTH  frame result.
out_sinal  output  1  signed mode: out_soma MSB; unsigned mode: 0.
out_overflow  output  1  sticky: any step of frame overflowed.
out_contagem  output  $clog2(MAX_OPERANDOS+1)  operands accepted in frame.

Behaviour:
- Reset (async assert, sync deassert released on clk):
  - state OCIOSO.
  - acc, out_soma, out_contagem, out_overflow, out_sinal = 0.
  - out_valid = 0, in_ready = 1.
  - A reset mid-frame discards the frame; no partial result is ever presented.
- Beat accepted when in_valid && in_ready at a rising clk.
- Per-beat arithmetic:
  - The operand is extended to ACC_WIDTH+1 bits: sign-extended if the frame mode is signed, zero-extended otherwise.
  - Negated if in_sub = 1, then added to the accumulator extended the same way.
  - Overflow, unsigned: exact result < 0 or > 2^ACC_WIDTH-1.
  - Overflow, signed: exact result < -2^(ACC_WIDTH-1) or > 2^(ACC_WIDTH-1)-1.
  - On overflow: SATURA=1 clamps to the nearest bound (unsigned 0 / all-ones; signed min / max); SATURA=0 keeps the low ACC_WIDTH bits.
  - out_overflow is set and stays set until the next frame starts.
- FSM states:
  - OCIOSO: in_ready=1, out_valid=0.
    - On accept: acc = 0 op beat, contagem = 1, overflow = 0, mode latched.
    - Go to RESULTADO if in_ultimo or MAX_OPERANDOS==1; else go to ACUMULA.
  - ACUMULA: in_ready=1.
    - On accept: acc updated, contagem+1.
    - Go to RESULTADO if in_ultimo or contagem reaches MAX_OPERANDOS.
    - No accept: hold.
  - RESULTADO: in_ready=0, out_valid=1.
    - out_* stable while out_ready=0.
    - On out_ready: go to OCIOSO, out_valid falls next cycle.
    - The next frame's first beat is accepted no earlier than the cycle after the handshake.
- Latency: out_valid rises on the clk edge that accepts the closing beat, so it is visible in the following cycle.
- modo_sinal changes mid-frame are ignored.
- in_ultimo on a beat that also hits MAX_OPERANDOS closes the frame once, not twice.
- out_soma, out_contagem and out_overflow are registered and change only on state updates.

Decomposition:
- Package acumulador_pkg holds:
  - state enum {OCIOSO, ACUMULA, RESULTADO};
  - the count-width function;
  - signed/unsigned mode constants.
- One combinational sub-module, somador_sat, takes acc, operand, sub, mode and SATURA, and returns the next acc plus an overflow bit. The FSM and registers stay in acumulador_param.

Test Plan:
- Defaults, unsigned: beats 8'b00000001, then 8'b00000001 with in_ultimo -> next cycle out_valid=1, out_soma=12'h002, out_contagem=2, out_overflow=0, out_sinal=0.
- Signed: beats 8'b10000000 twice, ultimo on second -> out_soma=12'hF00 (-256), out_sinal=1, out_overflow=0.
- Unsigned underflow: beat 0, then 1 with in_sub=1 and ultimo.
  - SATURA=0 -> out_soma=12'hFFF, out_overflow=1.
  - SATURA=1 -> out_soma=12'h000, out_overflow=1.
- Force-close: 16 beats of 8'h01, no in_ultimo -> result after 16th beat: out_soma=16, out_contagem=16, in_ready=0. A 17th in_valid stalls until the result handshake completes.
- Backpressure: out_ready=0 for 5 cycles in RESULTADO -> all out_* unchanged, in_ready=0. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-frame: rst_n low after 3 beats (between edges) -> immediately out_valid=0, out_soma=0, in_ready=1. A new frame 8'h05 with ultimo then gives out_soma=5, out_contagem=1.

Source files
------------

// File: rtl/acumulador_pkg.sv
// rtl/acumulador_pkg.sv - shared types and helpers for the streaming accumulator
package acumulador_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ACUMULA   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    localparam logic MODO_SEM_SINAL = 1'b0;
    localparam logic MODO_COM_SINAL = 1'b1;

    // Bits needed to hold a count from 0 up to and including max_operandos.
    function automatic int largura_contagem(input int max_operandos);
        return $clog2(max_operandos + 1);
    endfunction

endpackage

// File: rtl/somador_sat.sv
// rtl/somador_sat.sv - one accumulate step with overflow detection and optional clamp
module somador_sat
    import acumulador_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12,
    parameter int SATURA    = 0
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]     operando,
    input  logic                 sub,
    input  logic                 modo,
    output logic [ACC_WIDTH-1:0] acc_prox,
    output logic                 overflow
);

    // Two guard bits keep the exact result representable in both modes,
    // including the negation of the most negative signed operand.
    localparam int EW = ACC_WIDTH + 2;

    logic [EW-1:0] op_ext;
    logic [EW-1:0] acc_ext;
    logic [EW-1:0] termo;
    logic [EW-1:0] exato;
    logic [2:0]    topo;
    logic          com_sinal;

    always_comb begin
        com_sinal = (modo == MODO_COM_SINAL);
        op_ext    = {{(EW-WIDTH){com_sinal && operando[WIDTH-1]}}, operando};
        acc_ext   = {{2{com_sinal && acc[ACC_WIDTH-1]}}, acc};
        termo     = sub ? (~op_ext + {{(EW-1){1'b0}}, 1'b1}) : op_ext;
        exato     = acc_ext + termo;
        topo      = exato[EW-1:ACC_WIDTH-1];

        if (com_sinal) begin
            overflow = !((&topo) || (~|topo));
        end else begin
            overflow = |exato[EW-1:ACC_WIDTH];
        end

        acc_prox = exato[ACC_WIDTH-1:0];
        if ((SATURA != 0) && overflow) begin
            if (com_sinal) begin
                acc_prox = exato[EW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                acc_prox = exato[EW-1] ? {ACC_WIDTH{1'b0}} : {ACC_WIDTH{1'b1}};
            end
        end
    end

endmodule

// File: rtl/acumulador_param.sv
// rtl/acumulador_param.sv - framed streaming accumulator with result handshake
module acumulador_param
    import acumulador_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ACC_WIDTH     = 12,
    parameter int MAX_OPERANDOS = 16,
    parameter int SATURA        = 0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         modo_sinal,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [WIDTH-1:0]                             in_dado,
    input  logic                                         in_sub,
    input  logic                                         in_ultimo,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ACC_WIDTH-1:0]                         out_soma,
    output logic                                         out_sinal,
    output logic                                         out_overflow,
    output logic [largura_contagem(MAX_OPERANDOS)-1:0]   out_contagem
);

    localparam int CW = largura_contagem(MAX_OPERANDOS);
    localparam logic [CW-1:0] CONT_MAX = CW'(MAX_OPERANDOS);
    localparam logic [CW-1:0] CONT_UM  = CW'(1);

    estado_t              estado;
    estado_t              estado_prox;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] acc_prox;
    logic [CW-1:0]        contagem;
    logic [CW-1:0]        contagem_prox;
    logic                 overflow;
    logic                 ovf_passo;
    logic                 modo;
    logic                 modo_efetivo;
    logic                 inicio;
    logic                 aceita;
    logic                 fecha;

    // The first beat of a frame starts from zero with the live mode; later
    // beats use the mode latched at frame start.
    always_comb begin
        inicio        = (estado == OCIOSO);
        aceita        = in_valid && in_ready;
        acc_base      = inicio ? {ACC_WIDTH{1'b0}} : acc;
        modo_efetivo  = inicio ? modo_sinal : modo;
        contagem_prox = inicio ? CONT_UM : contagem + CONT_UM;
        fecha         = in_ultimo || (contagem_prox == CONT_MAX);
    end

    somador_sat #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SATURA    (SATURA)
    ) u_somador (
        .acc      (acc_base),
        .operando (in_dado),
        .sub      (in_sub),
        .modo     (modo_efetivo),
        .acc_prox (acc_prox),
        .overflow (ovf_passo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (estado)
            OCIOSO, ACUMULA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    estado_prox = fecha ? RESULTADO : ACUMULA;
                end
            end
            RESULTADO: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= {ACC_WIDTH{1'b0}};
            contagem <= {CW{1'b0}};
            overflow <= 1'b0;
            modo     <= MODO_SEM_SINAL;
        end else if (aceita) begin
            acc      <= acc_prox;
            contagem <= contagem_prox;
            overflow <= inicio ? ovf_passo : (overflow || ovf_passo);
            modo     <= modo_efetivo;
        end
    end

    assign out_soma     = acc;
    assign out_contagem = contagem;
    assign out_overflow = overflow;
    assign out_sinal    = (modo == MODO_COM_SINAL) && acc[ACC_WIDTH-1];

endmodule

// File: tb/tb_acumulador_param.sv
// tb/tb_acumulador_param.sv - bench for acumulador_param (wrapping and saturating instances)
module tb_acumulador_param;

    localparam int W  = 8;
    localparam int A  = 12;
    localparam int M  = 16;
    localparam int CW = $clog2(M + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic modo_sinal, in_valid, in_sub, in_ultimo, out_ready;
    logic [W-1:0] in_dado;

    logic in_ready_0, out_valid_0, out_sinal_0, out_overflow_0;
    logic [A-1:0] out_soma_0;
    logic [CW-1:0] out_contagem_0;
    logic in_ready_1, out_valid_1, out_sinal_1, out_overflow_1;
    logic [A-1:0] out_soma_1;
    logic [CW-1:0] out_contagem_1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acumulador_param #(.WIDTH(W), .ACC_WIDTH(A), .MAX_OPERANDOS(M), .SATURA(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .modo_sinal(modo_sinal),
        .in_valid(in_valid), .in_ready(in_ready_0), .in_dado(in_dado),
        .in_sub(in_sub), .in_ultimo(in_ultimo),
        .out_valid(out_valid_0), .out_ready(out_ready), .out_soma(out_soma_0),
        .out_sinal(out_sinal_0), .out_overflow(out_overflow_0),
        .out_contagem(out_contagem_0)
    );

    acumulador_param #(.WIDTH(W), .ACC_WIDTH(A), .MAX_OPERANDOS(M), .SATURA(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .modo_sinal(modo_sinal),
        .in_valid(in_valid), .in_ready(in_ready_1), .in_dado(in_dado),
        .in_sub(in_sub), .in_ultimo(in_ultimo),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_soma(out_soma_1),
        .out_sinal(out_sinal_1), .out_overflow(out_overflow_1),
        .out_contagem(out_contagem_1)
    );

    task automatic chk(input string nome, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Exact integer arithmetic: the result value, then range check, then wrap or clamp.
    function automatic void passo(input longint acc, input longint op, input bit sub,
                                  input bit mode, input bit sat,
                                  output longint nacc, output bit ovf);
        longint ex, lo, hi, span;
        span = longint'(1) << A;
        ex   = sub ? acc - op : acc + op;
        lo   = mode ? -(span / 2) : 0;
        hi   = mode ? (span / 2) - 1 : span - 1;
        ovf  = (ex < lo) || (ex > hi);
        if (!ovf) begin
            nacc = ex;
        end else if (sat) begin
            nacc = (ex < lo) ? lo : hi;
        end else begin
            nacc = ((ex % span) + span) % span;
            if (mode && nacc > hi) nacc = nacc - span;
        end
    endfunction

    bit     m_busy, m_in_frame, m_mode, m_ovf0, m_ovf1;
    longint m_acc0, m_acc1;
    int     m_cnt;

    bit     n_mode, n_ovf0, n_ovf1, n_close;
    longint n_acc0, n_acc1, n_op;
    int     n_cnt;

    always_comb begin
        n_mode  = m_in_frame ? m_mode : modo_sinal;
        n_op    = n_mode ? longint'($signed(in_dado)) : longint'(in_dado);
        n_acc0  = 0;
        n_acc1  = 0;
        n_ovf0  = 1'b0;
        n_ovf1  = 1'b0;
        passo(m_in_frame ? m_acc0 : 0, n_op, in_sub, n_mode, 1'b0, n_acc0, n_ovf0);
        passo(m_in_frame ? m_acc1 : 0, n_op, in_sub, n_mode, 1'b1, n_acc1, n_ovf1);
        n_cnt   = m_in_frame ? m_cnt + 1 : 1;
        n_close = in_ultimo || (n_cnt == M);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_in_frame <= 0; m_mode <= 0;
            m_acc0 <= 0; m_acc1 <= 0; m_ovf0 <= 0; m_ovf1 <= 0; m_cnt <= 0;
        end else if (m_busy) begin
            if (out_ready) m_busy <= 0;
        end else if (in_valid) begin
            m_acc0     <= n_acc0;
            m_acc1     <= n_acc1;
            m_ovf0     <= n_ovf0 | (m_in_frame & m_ovf0);
            m_ovf1     <= n_ovf1 | (m_in_frame & m_ovf1);
            m_cnt      <= n_cnt;
            m_mode     <= n_mode;
            m_in_frame <= !n_close;
            m_busy     <= n_close;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_0", in_ready_0, !m_busy);
            chk("out_valid_0", out_valid_0, m_busy);
            chk("in_ready_1", in_ready_1, !m_busy);
            chk("out_valid_1", out_valid_1, m_busy);
            if (m_busy) begin
                chk("soma_0", out_soma_0, m_acc0 & ((longint'(1) << A) - 1));
                chk("soma_1", out_soma_1, m_acc1 & ((longint'(1) << A) - 1));
                chk("sinal_0", out_sinal_0, m_mode && (m_acc0 < 0));
                chk("sinal_1", out_sinal_1, m_mode && (m_acc1 < 0));
                chk("ovf_0", out_overflow_0, m_ovf0);
                chk("ovf_1", out_overflow_1, m_ovf1);
                chk("cont_0", out_contagem_0, m_cnt);
                chk("cont_1", out_contagem_1, m_cnt);
            end
        end
    end

    task automatic beat(input logic [W-1:0] d, input bit sub, input bit ult, input bit modo);
        bit aceito = 0;
        int k = 0;
        in_valid = 1; in_dado = d; in_sub = sub; in_ultimo = ult; modo_sinal = modo;
        while (!aceito && k < 50) begin
            aceito = in_ready_0;
            @(posedge clk); #1;
            k++;
        end
        chk("beat_accept", aceito, 1);
        in_valid = 0; in_sub = 0; in_ultimo = 0;
    endtask

    task automatic handshake();
        int k = 0;
        while (!out_valid_0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("result_wait", out_valid_0, 1);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; modo_sinal = 0; in_valid = 0; in_sub = 0; in_ultimo = 0;
        out_ready = 0; in_dado = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_0, 0);
        chk("rst_in_ready", in_ready_0, 1);
        chk("rst_soma", out_soma_0, 0);
        chk("rst_cont", out_contagem_0, 0);
        chk("rst_ovf", out_overflow_0, 0);
        rst_n = 1;
        @(posedge clk); #1;

        beat(8'h01, 0, 0, 0);
        beat(8'h01, 0, 1, 0);
        chk("u_valid", out_valid_0, 1);
        chk("u_soma", out_soma_0, 12'h002);
        chk("u_cont", out_contagem_0, 2);
        chk("u_ovf", out_overflow_0, 0);
        chk("u_sinal", out_sinal_0, 0);
        handshake();

        beat(8'h80, 0, 0, 1);
        beat(8'h80, 0, 1, 0);
        chk("s_soma", out_soma_0, 12'hF00);
        chk("s_sinal", out_sinal_0, 1);
        chk("s_ovf", out_overflow_0, 0);
        handshake();

        beat(8'h00, 0, 0, 0);
        beat(8'h01, 1, 1, 0);
        chk("under_wrap_soma", out_soma_0, 12'hFFF);
        chk("under_wrap_ovf", out_overflow_0, 1);
        chk("under_sat_soma", out_soma_1, 12'h000);
        chk("under_sat_ovf", out_overflow_1, 1);
        handshake();

        for (int i = 0; i < M; i++) beat(8'h01, 0, 0, 0);
        chk("fc_valid", out_valid_0, 1);
        chk("fc_soma", out_soma_0, 16);
        chk("fc_cont", out_contagem_0, 16);
        chk("fc_in_ready", in_ready_0, 0);
        in_valid = 1; in_dado = 8'h07; in_ultimo = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_soma", out_soma_0, 16);
            chk("bp_cont", out_contagem_0, 16);
            chk("bp_in_ready", in_ready_0, 0);
            chk("bp_valid", out_valid_0, 1);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("hs_valid_low", out_valid_0, 0);
        chk("hs_in_ready", in_ready_0, 1);
        @(posedge clk); #1;
        in_valid = 0; in_ultimo = 0;
        chk("b17_soma", out_soma_0, 7);
        chk("b17_cont", out_contagem_0, 1);
        handshake();

        for (int i = 0; i < M; i++) beat(8'h80, 1, 0, 1);
        chk("sovf_wrap_soma", out_soma_0, 12'h800);
        chk("sovf_wrap_sinal", out_sinal_0, 1);
        chk("sovf_wrap_ovf", out_overflow_0, 1);
        chk("sovf_sat_soma", out_soma_1, 12'h7FF);
        chk("sovf_sat_sinal", out_sinal_1, 0);
        chk("sovf_sat_ovf", out_overflow_1, 1);
        handshake();

        for (int i = 0; i < 3; i++) beat(8'h02, 0, 0, 0);
        #3;
        rst_n = 0;
        #1;
        chk("mrst_valid", out_valid_0, 0);
        chk("mrst_soma", out_soma_0, 0);
        chk("mrst_in_ready", in_ready_0, 1);
        chk("mrst_cont", out_contagem_0, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        beat(8'h05, 0, 1, 0);
        chk("post_rst_soma", out_soma_0, 5);
        chk("post_rst_cont", out_contagem_0, 1);
        handshake();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
